// File: rtl/prp_pipe_pkg.sv
// Shared types for the PRP pipeline hazard controller: scoreboard entry, FSM states, select codes.
package prp_pipe_pkg;

    // Entries carry a fixed-width rd; narrower register files zero-extend into it.
    localparam int unsigned RegAddrWMax = 8;
    localparam int unsigned SEL_RF      = 0;

    typedef enum logic [0:0] {
        RUN,
        WAIT
    } fsm_e;

    typedef struct packed {
        logic                   valid;
        logic                   wr;
        logic [RegAddrWMax-1:0] rd;
        logic                   load;
    } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request and control-output bundle between the pipeline and the hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned SEL_W      = 3
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_ra;
    logic [REG_ADDR_W-1:0] id_rb;
    logic                  id_ra_used;
    logic                  id_rb_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_wr_en;
    logic                  id_is_load;
    logic                  id_is_nic;
    logic                  br_taken;
    logic                  nic_ready;
    logic                  stall;
    logic                  freeze;
    logic                  flush;
    logic [SEL_W-1:0]      fwd_sel_a;
    logic [SEL_W-1:0]      fwd_sel_b;
    logic                  nic_req;
    logic                  nic_timeout;
    logic [DEPTH-1:0]      stage_valid;

    modport master (
        output id_valid, id_ra, id_rb, id_ra_used, id_rb_used, id_rd, id_wr_en,
        output id_is_load, id_is_nic, br_taken, nic_ready,
        input  stall, freeze, flush, fwd_sel_a, fwd_sel_b, nic_req, nic_timeout, stage_valid
    );

    modport slave (
        input  id_valid, id_ra, id_rb, id_ra_used, id_rb_used, id_rd, id_wr_en,
        input  id_is_load, id_is_nic, br_taken, nic_ready,
        output stall, freeze, flush, fwd_sel_a, fwd_sel_b, nic_req, nic_timeout, stage_valid
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// In-flight writer shift register with youngest-first source match for both operands.
module pipe_scoreboard
    import prp_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned SEL_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   shift,
    input  sb_entry_t              ins,
    input  logic [RegAddrWMax-1:0] src_a,
    input  logic [RegAddrWMax-1:0] src_b,
    input  logic                   used_a,
    input  logic                   used_b,
    output logic [SEL_W-1:0]       sel_a,
    output logic [SEL_W-1:0]       sel_b,
    output logic                   load_a,
    output logic                   load_b,
    output logic [DEPTH-1:0]       valid
);

    sb_entry_t sb_q [1:DEPTH];

    function automatic logic hit(input sb_entry_t e, input logic [RegAddrWMax-1:0] src);
        return e.valid && e.wr && (e.rd == src);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= int'(DEPTH); k++) sb_q[k] <= '0;
        end else if (shift) begin
            sb_q[1] <= ins;
            for (int k = 2; k <= int'(DEPTH); k++) sb_q[k] <= sb_q[k-1];
        end
    end

    // Walk oldest to youngest so the youngest match overwrites.
    always_comb begin
        sel_a  = SEL_W'(SEL_RF);
        sel_b  = SEL_W'(SEL_RF);
        load_a = 1'b0;
        load_b = 1'b0;
        for (int k = int'(DEPTH); k >= 1; k--) begin
            if (used_a && hit(sb_q[k], src_a)) begin
                sel_a  = SEL_W'(k);
                load_a = sb_q[k].load;
            end
            if (used_b && hit(sb_q[k], src_b)) begin
                sel_b  = SEL_W'(k);
                load_b = sb_q[k].load;
            end
        end
    end

    always_comb begin
        valid = '0;
        for (int k = 1; k <= int'(DEPTH); k++) valid[k-1] = sb_q[k].valid;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding/stall controller: load-use stalls, NIC ready/timeout handshake, branch flush.
module pipe_hazard_ctrl
    import prp_pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned LOAD_STAGE  = 1,
    parameter int unsigned FLUSH_SLOTS = 1,
    parameter int unsigned NIC_TMO     = 15,
    parameter int unsigned SEL_W       = 3
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned      CntW         = $clog2(NIC_TMO + 1);
    localparam logic [SEL_W-1:0] LoadStageSel = SEL_W'(LOAD_STAGE);
    localparam logic [1:0]       FlushInit    = 2'(FLUSH_SLOTS - 1);

    fsm_e            state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      fcnt_q, fcnt_d;

    logic [SEL_W-1:0] sel_a, sel_b;
    logic             load_a, load_b;
    logic             in_wait, load_use, wait_done, shift;
    logic             stall_c, freeze_c, flush_c, nic_req_c, tmo_c;
    sb_entry_t        ins;

    pipe_scoreboard #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_scoreboard (
        .clk    (clk),
        .rst    (rst),
        .shift  (shift),
        .ins    (ins),
        .src_a  (RegAddrWMax'(bus.id_ra)),
        .src_b  (RegAddrWMax'(bus.id_rb)),
        .used_a (bus.id_ra_used),
        .used_b (bus.id_rb_used),
        .sel_a  (sel_a),
        .sel_b  (sel_b),
        .load_a (load_a),
        .load_b (load_b),
        .valid  (bus.stage_valid)
    );

    // Outputs are gated by rst so they read 0 while reset is held, whatever ID presents.
    always_comb begin
        in_wait   = (state_q == WAIT);
        load_use  = bus.id_valid && ((load_a && (sel_a < LoadStageSel)) ||
                                     (load_b && (sel_b < LoadStageSel)));
        stall_c   = rst && (in_wait || load_use);
        freeze_c  = rst && in_wait;
        nic_req_c = rst && (in_wait || (bus.id_valid && bus.id_is_nic && !stall_c));
        tmo_c     = rst && in_wait && !bus.nic_ready && (cnt_q == CntW'(NIC_TMO));
        flush_c   = rst && !stall_c && (bus.br_taken || (fcnt_q != 2'd0));
        wait_done = in_wait && (bus.nic_ready || tmo_c);
        shift     = !in_wait || wait_done;

        // A NIC access that misses ready in RUN leaves a bubble; it enters only on completion.
        ins = '0;
        if (bus.id_valid && (in_wait ? bus.nic_ready
                                     : (!stall_c && !flush_c && !(nic_req_c && !bus.nic_ready))))
        begin
            ins.valid = 1'b1;
            ins.wr    = bus.id_wr_en;
            ins.rd    = RegAddrWMax'(bus.id_rd);
            ins.load  = bus.id_is_load;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (nic_req_c && !bus.nic_ready) begin
                    state_d = WAIT;
                    cnt_d   = CntW'(1);
                end
            end
            WAIT: begin
                if (wait_done) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        fcnt_d = fcnt_q;
        if (bus.br_taken && !stall_c) begin
            fcnt_d = FlushInit;
        end else if ((fcnt_q != 2'd0) && !stall_c) begin
            fcnt_d = fcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign bus.stall       = stall_c;
    assign bus.freeze      = freeze_c;
    assign bus.flush       = flush_c;
    assign bus.nic_req     = nic_req_c;
    assign bus.nic_timeout = tmo_c;
    assign bus.fwd_sel_a   = sel_a;
    assign bus.fwd_sel_b   = sel_b;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: expectations queued when ID is driven, compared on the following falling edge.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .DEPTH(2), .SEL_W(3)) bus ();

    pipe_hazard_ctrl #(
        .REG_ADDR_W  (5),
        .DEPTH       (2),
        .LOAD_STAGE  (2),
        .FLUSH_SLOTS (3),
        .NIC_TMO     (15),
        .SEL_W       (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum {SStall, SFreeze, SFlush, SSelA, SSelB, SReq, STmo, SSv} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        int unsigned exp;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_val(input string tag, input int unsigned obs_v, input int unsigned exp_v);
        n_checks++;
        if (obs_v == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs_v, exp_v);
    endtask

    function automatic int unsigned obs(input sig_e s);
        case (s)
            SStall:  return int'(bus.stall);
            SFreeze: return int'(bus.freeze);
            SFlush:  return int'(bus.flush);
            SSelA:   return int'(bus.fwd_sel_a);
            SSelB:   return int'(bus.fwd_sel_b);
            SReq:    return int'(bus.nic_req);
            STmo:    return int'(bus.nic_timeout);
            default: return int'(bus.stage_valid);
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val(e.tag, obs(e.sig), e.exp);
        end
    end

    task automatic exp_sig(input string tag, input sig_e s, input int unsigned v);
        exp_q.push_back('{tag, s, v});
    endtask

    task automatic exp_quiet(input string tag);
        exp_sig({tag, "_stall"}, SStall, 0);
        exp_sig({tag, "_freeze"}, SFreeze, 0);
        exp_sig({tag, "_flush"}, SFlush, 0);
        exp_sig({tag, "_req"}, SReq, 0);
        exp_sig({tag, "_tmo"}, STmo, 0);
    endtask

    task automatic set_id(input logic v, input logic [4:0] ra, input logic ra_u,
                          input logic [4:0] rb, input logic rb_u, input logic [4:0] rd,
                          input logic wr, input logic ld, input logic nic);
        bus.id_valid   = v;
        bus.id_ra      = ra;
        bus.id_ra_used = ra_u;
        bus.id_rb      = rb;
        bus.id_rb_used = rb_u;
        bus.id_rd      = rd;
        bus.id_wr_en   = wr;
        bus.id_is_load = ld;
        bus.id_is_nic  = nic;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.br_taken  = 1'b0;
        bus.nic_ready = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #1;
        exp_quiet("rst");
        exp_sig("rst_sela", SSelA, 0);
        exp_sig("rst_selb", SSelB, 0);
        exp_sig("rst_sv", SSv, 0);
        #11 rst = 1'b1;

        // Back-to-back ALU forwarding: distance 1, 2, then out of range.
        cyc(); set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); exp_sig("alu_w_stall", SStall, 0);
        cyc(); set_id(1, 3, 1, 0, 0, 0, 0, 0, 0);
        exp_sig("alu_d1_sel", SSelA, 1); exp_sig("alu_d1_stall", SStall, 0);
        exp_sig("alu_d1_sv", SSv, 1);
        cyc(); exp_sig("alu_d2_sel", SSelA, 2); exp_sig("alu_d2_sv", SSv, 3);
        cyc(); exp_sig("alu_d3_sel", SSelA, 0);

        // Load-use: one stall cycle, bubble in entry 1, then forward from stage 2.
        cyc(); set_id(1, 0, 0, 0, 0, 5, 1, 1, 0); exp_sig("ld_w_stall", SStall, 0);
        cyc(); set_id(1, 5, 1, 0, 0, 0, 0, 0, 0);
        exp_sig("ld_use_stall", SStall, 1); exp_sig("ld_use_flush", SFlush, 0);
        cyc(); exp_sig("ld_after_stall", SStall, 0); exp_sig("ld_after_sel", SSelA, 2);
        exp_sig("ld_after_sv", SSv, 2);
        cyc(); idle(); exp_sig("ld_idle_stall", SStall, 0);

        // Youngest writer wins; unused operand selects RF.
        cyc(); set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
        cyc(); set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
        cyc(); set_id(1, 0, 0, 7, 1, 0, 0, 0, 0); exp_sig("yng_selb", SSelB, 1);
        cyc(); set_id(1, 0, 0, 7, 0, 0, 0, 0, 0); exp_sig("unused_selb", SSelB, 0);

        // NIC access, ready on the 4th wait cycle.
        cyc(); set_id(1, 0, 0, 0, 0, 9, 1, 1, 1);
        exp_sig("nic_c0_req", SReq, 1); exp_sig("nic_c0_freeze", SFreeze, 0);
        exp_sig("nic_c0_stall", SStall, 0);
        for (int j = 1; j <= 4; j++) begin
            cyc();
            bus.nic_ready = (j == 4);
            exp_sig($sformatf("nic_w%0d_req", j), SReq, 1);
            exp_sig($sformatf("nic_w%0d_freeze", j), SFreeze, 1);
            exp_sig($sformatf("nic_w%0d_stall", j), SStall, 1);
            exp_sig($sformatf("nic_w%0d_tmo", j), STmo, 0);
        end
        cyc(); idle(); set_id(1, 9, 1, 0, 0, 0, 0, 0, 0);
        exp_sig("nic_done_req", SReq, 0); exp_sig("nic_done_freeze", SFreeze, 0);
        exp_sig("nic_done_sv", SSv, 1); exp_sig("nic_lduse_stall", SStall, 1);
        cyc(); exp_sig("nic_fwd_sel", SSelA, 2); exp_sig("nic_fwd_stall", SStall, 0);
        cyc(); idle();
        cyc();

        // NIC access that never gets ready: timeout on wait cycle 15, entry 1 bubble.
        cyc(); set_id(1, 0, 0, 0, 0, 10, 1, 1, 1); exp_sig("tmo_c0_req", SReq, 1);
        for (int j = 1; j <= 15; j++) begin
            cyc();
            exp_sig($sformatf("tmo_w%0d_tmo", j), STmo, (j == 15) ? 1 : 0);
            exp_sig($sformatf("tmo_w%0d_freeze", j), SFreeze, 1);
            exp_sig($sformatf("tmo_w%0d_req", j), SReq, 1);
        end
        cyc(); idle(); set_id(1, 10, 1, 0, 0, 0, 0, 0, 0);
        exp_quiet("tmo_after");
        exp_sig("tmo_after_sv", SSv, 0); exp_sig("tmo_after_sel", SSelA, 0);

        // Branch flush of 3 slots.
        cyc(); idle(); bus.id_valid = 1'b1; bus.br_taken = 1'b1;
        exp_sig("br_c0_flush", SFlush, 1); exp_sig("br_c0_stall", SStall, 0);
        for (int j = 1; j <= 3; j++) begin
            cyc(); idle();
            exp_sig($sformatf("br_c%0d_flush", j), SFlush, (j < 3) ? 1 : 0);
        end

        // Branch during a load-use stall is ignored until re-presented.
        cyc(); set_id(1, 0, 0, 0, 0, 4, 1, 1, 0); exp_sig("brs_ld_flush", SFlush, 0);
        cyc(); set_id(1, 4, 1, 0, 0, 0, 0, 0, 0); bus.br_taken = 1'b1;
        exp_sig("brs_stall", SStall, 1); exp_sig("brs_noflush", SFlush, 0);
        cyc(); exp_sig("brs_re_flush", SFlush, 1); exp_sig("brs_re_stall", SStall, 0);
        for (int j = 1; j <= 3; j++) begin
            cyc(); idle();
            exp_sig($sformatf("brs_c%0d_flush", j), SFlush, (j < 3) ? 1 : 0);
        end

        // Asynchronous reset while waiting on the NIC.
        cyc(); set_id(1, 0, 0, 0, 0, 11, 1, 1, 1); exp_sig("arst_c0_req", SReq, 1);
        cyc(); exp_sig("arst_w1_freeze", SFreeze, 1);
        cyc(); exp_sig("arst_w2_freeze", SFreeze, 1);
        cyc(); bus.br_taken = 1'b1; rst = 1'b0;
        exp_quiet("arst_in");
        exp_sig("arst_in_sv", SSv, 0);
        @(negedge clk);
        #2;
        idle();
        rst = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            cyc();
            exp_sig($sformatf("arst_rel%0d_tmo", j), STmo, 0);
            exp_sig($sformatf("arst_rel%0d_freeze", j), SFreeze, 0);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
